associative_data_array_pipelined: RTL and testbench

Parametrised successor to the cache data-array building block: a NUMBER_WAYS × NUMBER_SETS array of per-way blockrams with byte-enabled writes, a valid/ready request port, a back-pressurable read-response port with a small response buffer, and optional post-reset clearing. It sits under the L1/L2 cache controllers, between tag-compare logic (which produces the one-hot way) and the refill/response path.

---
 rtl/associative_data_array_pipelined_pkg.sv | 16 +
 rtl/associative_data_array_pipelined_blockram.sv | 34 +++
 rtl/associative_data_array_pipelined.sv | 192 +++++++++++++++++++
 tb/tb_associative_data_array_pipelined.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/associative_data_array_pipelined_pkg.sv
// Shared types and constants for the pipelined associative data array.
package assoc_array_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int CREDIT_WIDTH = 2;
    localparam logic [CREDIT_WIDTH-1:0] MAX_CREDIT = 2'd2;

    function automatic int byte_en_width(input int element_width);
        return element_width / 8;
    endfunction

endpackage

// File: rtl/associative_data_array_pipelined_blockram.sv
// Single-port blockram with per-byte write enables; write-first read data.
module byte_enable_blockram #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    en_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] we_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Each byte lane independently returns either the new write byte or the stored byte.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    rdata_q[b*8 +: 8]       <= wdata_i[b*8 +: 8];
                end else begin
                    rdata_q[b*8 +: 8]       <= mem_q[addr_i][b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/associative_data_array_pipelined.sv
// Way-organised data array: per-way blockrams, credit-limited read pipeline, 2-entry response FIFO.
module associative_data_array_pipelined
    import assoc_array_pkg::*;
#(
    parameter int ELEMENT_WIDTH  = 512,
    parameter int NUMBER_SETS    = 64,
    parameter int NUMBER_WAYS    = 16,
    parameter int SET_PTR_WIDTH  = $clog2(NUMBER_SETS),
    parameter int OUTPUT_REG     = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int BE_WIDTH      = byte_en_width(ELEMENT_WIDTH)
) (
    input  logic                     clk_in,
    input  logic                     reset_n_in,
    input  logic                     req_valid_in,
    output logic                     req_ready_out,
    input  logic                     req_write_in,
    input  logic [SET_PTR_WIDTH-1:0] req_set_in,
    input  logic [NUMBER_WAYS-1:0]   req_way_in,
    input  logic [BE_WIDTH-1:0]      req_byte_en_in,
    input  logic [ELEMENT_WIDTH-1:0] req_data_in,
    output logic                     resp_valid_out,
    input  logic                     resp_ready_in,
    output logic [ELEMENT_WIDTH-1:0] resp_data_out,
    output logic                     busy_out,
    output logic                     state_dbg_out
);

    localparam logic [SET_PTR_WIDTH-1:0] LAST_SET = SET_PTR_WIDTH'(NUMBER_SETS - 1);
    localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_e                     state_q, state_d;
    logic [SET_PTR_WIDTH-1:0]   clr_set_q, clr_set_d;
    logic [CREDIT_WIDTH-1:0]    credit_q, credit_d;
    logic                       clearing;
    logic                       req_accept, rd_accept, wr_accept, resp_pop;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q   <= RESET_STATE;
            clr_set_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_set_q <= clr_set_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_set_d = clr_set_q;
        clearing  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clearing  = 1'b1;
                clr_set_d = clr_set_q + SET_PTR_WIDTH'(1);
                if (clr_set_q == LAST_SET) begin
                    state_d   = ST_RUN;
                    clr_set_d = '0;
                end
            end
            ST_RUN: ;
            default: state_d = RESET_STATE;
        endcase
    end

    // Valid/ready: a request transfers on a rising edge where req_valid_in && req_ready_out;
    // a response transfers where resp_valid_out && resp_ready_in. Ready never depends on valid.
    assign req_ready_out = (state_q == ST_RUN) && (credit_q < MAX_CREDIT);
    assign req_accept    = req_valid_in && req_ready_out;
    assign rd_accept     = req_accept && !req_write_in;
    assign wr_accept     = req_accept && req_write_in;
    assign busy_out      = clearing;
    assign state_dbg_out = state_q;

    logic                     ram_en;
    logic [SET_PTR_WIDTH-1:0] ram_addr;
    logic [ELEMENT_WIDTH-1:0] ram_wdata;
    logic [BE_WIDTH-1:0]      ram_we    [NUMBER_WAYS];
    logic [ELEMENT_WIDTH-1:0] ram_rdata [NUMBER_WAYS];

    always_comb begin
        ram_en    = clearing || req_accept;
        ram_addr  = clearing ? clr_set_q : req_set_in;
        ram_wdata = clearing ? '0 : req_data_in;
    end

    for (genvar w = 0; w < NUMBER_WAYS; w++) begin : g_way
        assign ram_we[w] = clearing ? '1 :
                           ((wr_accept && req_way_in[w]) ? req_byte_en_in : '0);

        byte_enable_blockram #(
            .DATA_WIDTH (ELEMENT_WIDTH),
            .DEPTH      (NUMBER_SETS),
            .ADDR_WIDTH (SET_PTR_WIDTH)
        ) u_ram (
            .clk_i   (clk_in),
            .en_i    (ram_en),
            .addr_i  (ram_addr),
            .we_i    (ram_we[w]),
            .wdata_i (ram_wdata),
            .rdata_o (ram_rdata[w])
        );
    end

    // Stage 1: way select travels alongside the RAM read.
    logic                     s1_valid_q;
    logic [NUMBER_WAYS-1:0]   s1_way_q;
    logic [ELEMENT_WIDTH-1:0] mux_data;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            s1_valid_q <= 1'b0;
            s1_way_q   <= '0;
        end else begin
            s1_valid_q <= rd_accept;
            if (rd_accept) begin
                s1_way_q <= req_way_in;
            end
        end
    end

    always_comb begin
        mux_data = '0;
        for (int w = 0; w < NUMBER_WAYS; w++) begin
            if (s1_way_q[w]) begin
                mux_data = mux_data | ram_rdata[w];
            end
        end
    end

    logic                     push_valid;
    logic [ELEMENT_WIDTH-1:0] push_data;

    if (OUTPUT_REG != 0) begin : g_out_reg
        logic                     s2_valid_q;
        logic [ELEMENT_WIDTH-1:0] s2_data_q;

        always_ff @(posedge clk_in or negedge reset_n_in) begin
            if (!reset_n_in) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= mux_data;
                end
            end
        end

        assign push_valid = s2_valid_q;
        assign push_data  = s2_data_q;
    end else begin : g_no_out_reg
        assign push_valid = s1_valid_q;
        assign push_data  = mux_data;
    end

    // Credits bound outstanding reads to the FIFO depth, so a push always finds room.
    logic [ELEMENT_WIDTH-1:0] fifo_q [2];
    logic                     wr_ptr_q, rd_ptr_q;
    logic [1:0]               count_q, count_d;

    assign resp_valid_out = (count_q != 2'd0);
    assign resp_data_out  = fifo_q[rd_ptr_q];
    assign resp_pop       = resp_valid_out && resp_ready_in;

    always_comb begin
        count_d  = count_q + 2'(push_valid) - 2'(resp_pop);
        credit_d = credit_q + CREDIT_WIDTH'(rd_accept) - CREDIT_WIDTH'(resp_pop);
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            credit_q  <= '0;
        end else begin
            if (push_valid) begin
                fifo_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (resp_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q  <= count_d;
            credit_q <= credit_d;
        end
    end

endmodule

// File: tb/tb_associative_data_array_pipelined.sv
// Directed bench for associative_data_array_pipelined: clear, byte enables, streaming, back-pressure, reset.
module tb_associative_data_array_pipelined;
    import assoc_array_pkg::*;

    localparam int EW  = 512;
    localparam int NS  = 64;
    localparam int NW  = 16;
    localparam int SPW = 6;
    localparam int BEW = 64;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic           req_valid  = 1'b0;
    logic           req_write  = 1'b0;
    logic [SPW-1:0] req_set    = '0;
    logic [NW-1:0]  req_way    = '0;
    logic [BEW-1:0] req_be     = '0;
    logic [EW-1:0]  req_data   = '0;
    logic           resp_ready = 1'b0;
    logic           req_ready;
    logic           resp_valid;
    logic [EW-1:0]  resp_data;
    logic           busy;
    logic           state_dbg;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    logic [EW-1:0] got_q[$];
    int            got_t[$];
    logic [EW-1:0] exp_q[$];

    associative_data_array_pipelined #(
        .ELEMENT_WIDTH  (EW),
        .NUMBER_SETS    (NS),
        .NUMBER_WAYS    (NW),
        .SET_PTR_WIDTH  (SPW),
        .OUTPUT_REG     (1),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk_in         (clk),
        .reset_n_in     (rst_n),
        .req_valid_in   (req_valid),
        .req_ready_out  (req_ready),
        .req_write_in   (req_write),
        .req_set_in     (req_set),
        .req_way_in     (req_way),
        .req_byte_en_in (req_be),
        .req_data_in    (req_data),
        .resp_valid_out (resp_valid),
        .resp_ready_in  (resp_ready),
        .resp_data_out  (resp_data),
        .busy_out       (busy),
        .state_dbg_out  (state_dbg)
    );

    always @(posedge clk) edge_n <= edge_n + 1;

    // Capture every response that will pop on the coming rising edge.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            got_q.push_back(resp_data);
            got_t.push_back(edge_n);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog elapsed=%0t limit=1ms", $time);
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [SPW-1:0] set, input logic [NW-1:0] way,
                            input logic [BEW-1:0] be, input logic [EW-1:0] data,
                            output int acc_edge);
        int guard;
        guard     = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_set   = set;
        req_way   = way;
        req_be    = be;
        req_data  = data;
        while (req_ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        tick();
        acc_edge  = edge_n;
        req_valid = 1'b0;
        req_write = 1'b0;
        checks++;
        if (guard >= 200) begin
            failures++;
            $display("FAIL write_accept_timeout set=%0d waited=%0d limit=200", set, guard);
        end
    endtask

    task automatic do_read(input logic [SPW-1:0] set, input logic [NW-1:0] way, output int acc_edge);
        int guard;
        guard     = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_set   = set;
        req_way   = way;
        req_be    = '0;
        req_data  = '0;
        while (req_ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        tick();
        acc_edge  = edge_n;
        req_valid = 1'b0;
        checks++;
        if (guard >= 200) begin
            failures++;
            $display("FAIL read_accept_timeout set=%0d waited=%0d limit=200", set, guard);
        end
    endtask

    task automatic wait_resp(input int n);
        int guard;
        guard = 0;
        while (got_q.size() < n && guard < 200) begin
            tick();
            guard++;
        end
        checks++;
        if (got_q.size() < n) begin
            failures++;
            $display("FAIL resp_timeout got=%0d responses required=%0d", got_q.size(), n);
        end
    endtask

    task automatic read_one(input logic [SPW-1:0] set, input logic [NW-1:0] way, output logic [EW-1:0] data);
        int acc;
        got_q.delete();
        got_t.delete();
        do_read(set, way, acc);
        wait_resp(1);
        if (got_q.size() > 0) begin
            data = got_q.pop_front();
            void'(got_t.pop_front());
        end else begin
            data = 'x;
        end
    endtask

    task automatic count_clear(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        resp_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b required=0", req_ready); end
        checks++;
        if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b required=0", resp_valid); end
        checks++;
        if (resp_data !== '0) begin failures++; $display("FAIL reset_resp_data got=%h required=0", resp_data); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b required=1", busy); end
    endtask

    task automatic test_clear();
        int n;
        logic [EW-1:0] d;
        rst_n = 1'b1;
        count_clear(n);
        checks++;
        if (n !== NS) begin failures++; $display("FAIL clear_cycles got=%0d required=%0d", n, NS); end
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL clear_ready_after got=%b required=1", req_ready); end
        checks++;
        if (state_dbg !== ST_RUN) begin failures++; $display("FAIL clear_state_after got=%b required=%b", state_dbg, ST_RUN); end
        for (int s = 0; s < NS; s++) begin
            read_one(SPW'(s), '1, d);
            checks++;
            if (d !== '0) begin failures++; $display("FAIL clear_set%0d_all_ways got=%h required=0", s, d); end
        end
        read_one(6'd63, 16'h8000, d);
        checks++;
        if (d !== '0) begin failures++; $display("FAIL clear_set63_way15 got=%h required=0", d); end
    endtask

    task automatic test_byte_enable();
        int acc;
        logic [EW-1:0] d;
        logic [EW-1:0] exp;
        do_write(6'd5, 16'h0008, '1, {64{8'h55}}, acc);
        do_write(6'd5, 16'h0008, 64'h0F, {64{8'hAA}}, acc);
        exp = {64{8'h55}};
        exp[31:0] = 32'hAAAA_AAAA;
        read_one(6'd5, 16'h0008, d);
        checks++;
        if (d !== exp) begin failures++; $display("FAIL be_merge got=%h required=%h", d, exp); end
        read_one(6'd5, 16'h0004, d);
        checks++;
        if (d !== '0) begin failures++; $display("FAIL be_other_way got=%h required=0", d); end

        do_write(6'd7, 16'h0003, '1, {16{32'h1234_5678}}, acc);
        read_one(6'd7, 16'h0001, d);
        checks++;
        if (d !== {16{32'h1234_5678}}) begin failures++; $display("FAIL multihot_write_way0 got=%h required=%h", d, {16{32'h1234_5678}}); end
        read_one(6'd7, 16'h0002, d);
        checks++;
        if (d !== {16{32'h1234_5678}}) begin failures++; $display("FAIL multihot_write_way1 got=%h required=%h", d, {16{32'h1234_5678}}); end
        do_write(6'd7, 16'h0000, '1, {16{32'hDEAD_BEEF}}, acc);
        read_one(6'd7, 16'h0001, d);
        checks++;
        if (d !== {16{32'h1234_5678}}) begin failures++; $display("FAIL zerohot_write got=%h required=%h", d, {16{32'h1234_5678}}); end

        do_write(6'd8, 16'h0001, '1, {16{32'h0000_00F0}}, acc);
        do_write(6'd8, 16'h0002, '1, {16{32'h0F00_0000}}, acc);
        read_one(6'd8, 16'h0003, d);
        checks++;
        if (d !== {16{32'h0F00_00F0}}) begin failures++; $display("FAIL multihot_read got=%h required=%h", d, {16{32'h0F00_00F0}}); end
        read_one(6'd8, 16'h0000, d);
        checks++;
        if (d !== '0) begin failures++; $display("FAIL zerohot_read got=%h required=0", d); end
    endtask

    task automatic test_read_after_write();
        int acc_w, acc_r;
        logic [EW-1:0] d;
        do_write(6'd9, 16'h0001, '1, {16{32'h1111_1111}}, acc_w);
        got_q.delete();
        got_t.delete();
        do_write(6'd9, 16'h0001, '1, {16{32'hCAFE_F00D}}, acc_w);
        do_read(6'd9, 16'h0001, acc_r);
        checks++;
        if (acc_r - acc_w !== 1) begin failures++; $display("FAIL raw_edge_gap got=%0d required=1", acc_r - acc_w); end
        wait_resp(1);
        d = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        checks++;
        if (d !== {16{32'hCAFE_F00D}}) begin failures++; $display("FAIL raw_data got=%h required=%h", d, {16{32'hCAFE_F00D}}); end
    endtask

    task automatic test_streaming();
        int acc, acc0;
        logic [31:0] word;
        logic [EW-1:0] d, e;
        exp_q.delete();
        for (int s = 0; s < 8; s++) begin
            word = 32'(s) * 32'h0101_0101 + 32'h0A0B_0C0D;
            do_write(SPW'(16 + s), 16'h0002, '1, {16{word}}, acc);
            exp_q.push_back({16{word}});
        end
        got_q.delete();
        got_t.delete();
        do_read(6'd16, 16'h0002, acc0);
        for (int s = 1; s < 8; s++) begin
            do_read(SPW'(16 + s), 16'h0002, acc);
        end
        wait_resp(8);
        if (got_t.size() > 0) begin
            checks++;
            if (got_t[0] - acc0 !== 2) begin failures++; $display("FAIL stream_first_latency got=%0d required=2", got_t[0] - acc0); end
        end
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            d = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            checks++;
            if (d !== e) begin failures++; $display("FAIL stream_resp%0d got=%h required=%h", i, d, e); end
        end
    endtask

    task automatic test_back_pressure();
        int acc, third_edge, guard, w_acc;
        logic rdy;
        logic [EW-1:0] d, e;
        exp_q.delete();
        for (int s = 0; s < 4; s++) begin
            do_write(SPW'(20 + s), 16'h0010, '1, {8{32'(s + 1) * 32'h1357_9BDF, 32'hF0F0_0000}}, w_acc);
            exp_q.push_back({8{32'(s + 1) * 32'h1357_9BDF, 32'hF0F0_0000}});
        end
        resp_ready = 1'b0;
        got_q.delete();
        got_t.delete();
        acc = 0;
        third_edge = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_set   = SPW'(20 + acc);
            req_way   = 16'h0010;
            rdy = req_ready;
            tick();
            if (rdy) acc++;
        end
        checks++;
        if (acc !== 2) begin failures++; $display("FAIL bp_accepted got=%0d required=2", acc); end
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b required=0", req_ready); end
        checks++;
        if (resp_valid !== 1'b1) begin failures++; $display("FAIL bp_resp_valid got=%b required=1", resp_valid); end
        resp_ready = 1'b1;
        guard = 0;
        while (acc < 4 && guard < 40) begin
            req_set = SPW'(20 + acc);
            rdy = req_ready;
            tick();
            if (rdy) begin
                acc++;
                if (acc == 3) third_edge = edge_n;
            end
            guard++;
        end
        req_valid = 1'b0;
        checks++;
        if (acc !== 4) begin failures++; $display("FAIL bp_release_accepted got=%0d required=4", acc); end
        wait_resp(4);
        if (got_t.size() > 0) begin
            checks++;
            if (third_edge < got_t[0] + 2) begin
                failures++;
                $display("FAIL bp_third_after_pop got=edge%0d required>=edge%0d", third_edge, got_t[0] + 2);
            end
        end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            d = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            checks++;
            if (d !== e) begin failures++; $display("FAIL bp_resp%0d got=%h required=%h", i, d, e); end
        end
    endtask

    task automatic test_mid_reset();
        int acc, n;
        logic [EW-1:0] d;
        do_write(6'd30, 16'h0001, '1, {16{32'h7777_8888}}, acc);
        resp_ready = 1'b0;
        do_read(6'd30, 16'h0001, acc);
        do_read(6'd30, 16'h0001, acc);
        repeat (4) tick();
        checks++;
        if (resp_valid !== 1'b1) begin failures++; $display("FAIL mr_buffered_valid got=%b required=1", resp_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin failures++; $display("FAIL mr_valid_dropped got=%b required=0", resp_valid); end
        checks++;
        if (resp_data !== '0) begin failures++; $display("FAIL mr_data_zero got=%h required=0", resp_data); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL mr_busy got=%b required=1", busy); end
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL mr_ready got=%b required=0", req_ready); end
        tick();
        rst_n = 1'b1;
        count_clear(n);
        checks++;
        if (n !== NS) begin failures++; $display("FAIL mr_clear_cycles got=%0d required=%0d", n, NS); end
        got_q.delete();
        got_t.delete();
        resp_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (got_q.size() !== 0) begin failures++; $display("FAIL mr_stale_resp got=%0d responses required=0", got_q.size()); end
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL mr_credit_zero_ready got=%b required=1", req_ready); end
        read_one(6'd30, 16'h0001, d);
        checks++;
        if (d !== '0) begin failures++; $display("FAIL mr_recleared got=%h required=0", d); end
    endtask

    initial begin
        #1;
        test_reset();
        test_clear();
        test_byte_enable();
        test_read_after_write();
        test_streaming();
        test_back_pressure();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
